// File: rtl/multi_clock_divider.sv
// multi_clock_divider
//   N-channel programmable divider. Each channel produces a 50%-duty divided
//   clock (period 2*M system clocks) and a one-cycle tick on every rising
//   transition of that divided clock. Half-periods are double-buffered:
//   a write lands in a shadow register and is only applied at a terminal
//   count, on restart, or while the channel is disabled, so a running
//   waveform never sees a truncated phase.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable        per-channel run enable
//   sync_restart  synchronous pulse, zeroes every channel in phase
//   wr_en         divisor write strobe
//   wr_ch         write target channel (indices >= N_CH are ignored)
//   wr_data       new half-period in clk cycles (0 is stored as 1)
//   divided_clk   divided clock per channel
//   tick          one-clk pulse per divided_clk rising transition
//   pending       shadow written but not yet applied
module multi_clock_divider #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned DEFAULT_M = 50000000,
    parameter int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  enable,
    input  logic             sync_restart,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_data,
    output logic [N_CH-1:0]  divided_clk,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending
);

    localparam logic [CNT_W-1:0] M_RST = (DEFAULT_M == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_M);

    logic [CNT_W-1:0] count    [N_CH];
    logic [CNT_W-1:0] m_active [N_CH];
    logic [CNT_W-1:0] m_shadow [N_CH];
    logic [N_CH-1:0]  wr_sel;
    logic [CNT_W-1:0] wr_m;

    // Zero half-period is meaningless; clamp to the fastest legal divide.
    assign wr_m = (wr_data == '0) ? CNT_W'(1) : wr_data;

    // Equality decode: out-of-range channel indices simply match nothing.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                count[i]    <= '0;
                m_active[i] <= M_RST;
                m_shadow[i] <= M_RST;
            end
            divided_clk <= '0;
            tick        <= '0;
            pending     <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (sync_restart || !enable[i]) begin
                    count[i]       <= '0;
                    divided_clk[i] <= 1'b0;
                    tick[i]        <= 1'b0;
                    if (pending[i]) begin
                        m_active[i] <= m_shadow[i];
                    end
                    pending[i] <= 1'b0;
                end else if (count[i] == m_active[i] - CNT_W'(1)) begin
                    count[i]       <= '0;
                    divided_clk[i] <= ~divided_clk[i];
                    tick[i]        <= ~divided_clk[i];
                    if (pending[i]) begin
                        m_active[i] <= m_shadow[i];
                    end
                    pending[i] <= 1'b0;
                end else begin
                    count[i] <= count[i] + CNT_W'(1);
                    tick[i]  <= 1'b0;
                end
                // Placed after the apply logic: a same-edge write consumes
                // nothing, it re-arms pending with the fresh value.
                if (wr_sel[i]) begin
                    m_shadow[i] <= wr_m;
                    pending[i]  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
module tb_multi_clock_divider;

    localparam int unsigned NC = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned DM = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] enable;
    logic          sync_restart;
    logic          wr_en;
    logic [2:0]    wr_ch;
    logic [CW-1:0] wr_data;
    logic [NC-1:0] divided_clk;
    logic [NC-1:0] tick;
    logic [NC-1:0] pending;

    int unsigned total = 0;
    int unsigned bad   = 0;

    multi_clock_divider #(
        .N_CH(NC),
        .CNT_W(CW),
        .DEFAULT_M(DM),
        .CH_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .sync_restart(sync_restart),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_data(wr_data),
        .divided_clk(divided_clk),
        .tick(tick),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model in absolute time: each channel remembers the edge
    // number at which its current half-period began, and toggles when
    // exactly m_act edges have elapsed since then.
    longint unsigned cyc;
    longint unsigned start [NC];
    int unsigned     m_act [NC];
    int unsigned     m_sh  [NC];
    bit              lvl   [NC];
    bit              tk    [NC];
    bit              pend  [NC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [NC-1:0] pack(input bit v [NC]);
        logic [NC-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            start[i] = cyc;
            m_act[i] = DM;
            m_sh[i]  = DM;
            lvl[i]   = 1'b0;
            tk[i]    = 1'b0;
            pend[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NC; i++) begin
            if (sync_restart || !enable[i]) begin
                lvl[i] = 1'b0;
                tk[i]  = 1'b0;
                if (pend[i]) m_act[i] = m_sh[i];
                pend[i]  = 1'b0;
                start[i] = cyc;
            end else if (cyc - start[i] == longint'(m_act[i])) begin
                lvl[i] = !lvl[i];
                tk[i]  = lvl[i];
                if (pend[i]) m_act[i] = m_sh[i];
                pend[i]  = 1'b0;
                start[i] = cyc;
            end else begin
                tk[i] = 1'b0;
            end
            if (wr_en && int'(wr_ch) == i) begin
                m_sh[i] = (wr_data == 0) ? 1 : int'(wr_data);
                pend[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("divided_clk", 32'(divided_clk), 32'(pack(lvl)));
        check("tick",        32'(tick),        32'(pack(tk)));
        check("pending",     32'(pending),     32'(pack(pend)));
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0;
        sync_restart = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write(input int ch, input int data);
        wr_en   = 1'b1;
        wr_ch   = 3'(ch);
        wr_data = CW'(data);
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b0;
        enable = '0;
        sync_restart = 1'b0;
        wr_en = 1'b0;
        wr_ch = '0;
        wr_data = '0;
        model_reset();
        @(negedge clk);
        idle(5);

        // Reset release, channel 0 only: rise at edge 3, fall at edge 6.
        rst_n = 1'b1;
        enable = 4'b0001;
        step(); step();
        check("ch0_not_yet", 32'(divided_clk[0]), 32'd0);
        step();
        check("ch0_rise_e3", 32'(divided_clk[0]), 32'd1);
        check("ch0_tick_e3", 32'(tick[0]), 32'd1);
        idle(11);

        // Divisor values including the zero clamp.
        write(1, 1);
        write(2, 0);
        write(3, 5);
        enable = 4'b1111;
        idle(24);

        // Glitch-free change: set M=4, let it apply, then change mid half-period.
        write(0, 4);
        for (int k = 0; k < 20 && pend[0]; k++) step();
        check("m4_applied", 32'(pending[0]), 32'd0);
        idle(2);
        write(0, 2);
        check("pending_mid", 32'(pending[0]), 32'd1);
        idle(14);

        // Write landing exactly on a terminal edge.
        write(0, 3);
        for (int k = 0; k < 20 && pend[0]; k++) step();
        for (int k = 0; k < 20 && (cyc + 1 - start[0] != longint'(m_act[0])); k++) step();
        write(0, 7);
        check("pending_after_term_wr", 32'(pending[0]), 32'd1);
        idle(30);

        // Synchronous restart with channels out of phase.
        write(1, 3);
        write(2, 4);
        idle(5);
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        check("restart_zero", 32'(divided_clk), 32'd0);
        idle(12);

        // Drop enable[2] with a write pending: applied immediately.
        write(2, 6);
        enable = 4'b1011;
        step();
        check("dis_clk2", 32'(divided_clk[2]), 32'd0);
        check("dis_pend2", 32'(pending[2]), 32'd0);
        enable = 4'b1111;
        idle(14);

        // Out-of-range channel writes leave everything unchanged.
        write(4, 9);
        write(7, 2);
        check("oor_pending", 32'(pending), 32'd0);
        idle(6);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_clk",  32'(divided_clk), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        check("async_pend", 32'(pending), 32'd0);
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(8);

        // Largest legal half-period.
        write(3, 255);
        sync_restart = 1'b1;
        step();
        idle(520);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            sync_restart = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) enable = NC'($urandom);
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_ch   = 3'($urandom_range(0, 7));
            wr_data = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255))
                                                  : CW'($urandom_range(0, 6));
            step();
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- N-channel programmable clock divider that generates 50%-duty divided clocks plus a one-cycle tick per divided period, all from the single system clock.
- Each channel has its own runtime-writable half-period, double-buffered so that a divisor change never produces a runtime glitch or truncated phase.
- A global restart aligns all channel phases.
- Feeds display scan, sort-step pacing and debounce logic.

Parameters:
- N_CH, 4, number of independent channels.
- CNT_W, 32, width of divisor and counter.
- DEFAULT_M, 50000000, half-period loaded into every channel at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  N_CH  per-channel run enable; bit i controls channel i.
- sync_restart  in  1  synchronous pulse; restarts all channels in phase.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  $clog2(N_CH) (min 1)  target channel of the write.
- wr_data  in  CNT_W  new half-period M, in clk cycles.
- divided_clk  out  N_CH  divided clock per channel, period 2*M.
- tick  out  N_CH  one-clk pulse on each 0->1 transition of divided_clk.
- pending  out  N_CH  shadow divisor written but not yet applied.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, divided_clk=0, tick=0, pending=0.
  - m_active=m_shadow=DEFAULT_M for every channel.
  - All outputs are registered.
- Write:
  - On wr_en with wr_ch<N_CH: m_shadow[wr_ch] <= (wr_data==0 ? 1 : wr_data) and pending[wr_ch] <= 1.
  - wr_ch>=N_CH: write ignored, no state change.
  - Back-to-back writes to one channel: the last write wins.
- Priority per channel per edge: sync_restart > disabled > terminal count > increment.
- sync_restart=1 (all channels, regardless of enable):
  - count<=0, divided_clk<=0, tick<=0.
  - Any pending shadow is copied to m_active and pending is cleared.
- enable[i]=0:
  - count<=0, divided_clk[i]<=0, tick[i]<=0.
  - A pending shadow is applied immediately and pending[i] cleared.
- enable[i]=1 and count==m_active-1 (terminal count):
  - count<=0 and divided_clk[i] toggles.
  - tick[i]<=1 only if divided_clk[i] was 0 (rising transition); otherwise tick<=0.
  - If pending[i], m_active<=m_shadow and pending[i]<=0. The new value governs the next half-period.
- enable[i]=1 otherwise: count<=count+1, tick[i]<=0.
- Timing:
  - Half-period is exactly M clk cycles, so the period is 2*M; M=1 gives clk/2.
  - After enable is sampled high with count=0, divided_clk rises on the M-th subsequent edge.
- Simultaneous write and terminal count on the same channel:
  - The terminal count applies the shadow value held before that edge.
  - The freshly written value is stored in the shadow and stays pending until the next terminal count.
- Wrap-around:
  - count never exceeds m_active-1; no CNT_W overflow is possible.
  - M=2^CNT_W-1 is legal.
- Reset asserted mid-period: immediate return to reset values; no partial tick is emitted.
- Channels are fully independent except for sync_restart and the shared write port.

Test Plan:
- Reset/default: hold rst_n low 5 cycles with DEFAULT_M overridden to 3 -> all outputs 0. Release with enable=4'b0001 -> divided_clk[0] rises on edge 3, falls on edge 6, period 6 clk. tick[0] is high one cycle coincident with each rise; other channels stay 0.
- Divisor values: write ch1=1, ch2=0, ch3=5, then enable all -> ch1 and ch2 run at clk/2 (0 is stored as 1), ch3 at period 10. Each tick is one cycle wide.
- Glitch-free change: ch0 running with M=4; write M=2 mid half-period -> pending[0]=1. The current half-period completes at 4 cycles, pending clears at that edge, and subsequent half-periods are 2 cycles.
- Write on terminal count: ch0 M=3; write M=7 on the exact terminal edge -> the next half-period is 3, pending stays 1, and half-periods are 7 after the following terminal.
- Restart and enable: channels out of phase; pulse sync_restart -> all counts and outputs are 0 next cycle and the channels then rise together. Dropping enable[2] mid-period -> divided_clk[2]=0 next edge and a pending write is applied immediately.
- Async reset mid-operation: assert rst_n between clock edges -> outputs 0 without waiting for clk; out-of-range wr_ch=4 (N_CH=4 requires an index width of 3 for this test) is ignored.
